// File: rtl/jtdd_com_pkg.sv
// Shared constants and state encoding for the main CPU <-> MCU communication stage.
package jtdd_com_pkg;
  localparam int COM_AW         = 9;
  localparam int COM_BA_TIMEOUT = 255;
  localparam int COM_IRQ_LEN    = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HALT_REQ = 2'd1,
    HALTED   = 2'd2,
    RELEASE  = 2'd3
  } com_state_e;
endpackage

// File: rtl/jtdd_mcu_com_if.sv
// Main CPU / MCU signal bundle of the communication stage.
// With JTDD_COM_GUARD_EN defined, the bundle also carries the guard violation counter.
interface jtdd_mcu_com_if #(parameter int AW = 9);
  logic          cpu_cen, mcu_cen;
  logic          com_cs, RnW;
  logic [AW-1:0] cpu_AB;
  logic [7:0]    cpu_dout;
  logic          mcu_halt, mcu_nmi_set;
  logic [7:0]    mcu_ram;
  logic          mcu_ban, mcu_irqmain;
  logic [AW-1:0] mcu_A;
  logic          mcu_cs, mcu_wr;
  logic [7:0]    mcu_dout, mcu_din;
  logic          mcu_haltn, mcu_ba, mcu_nmin, mcu_nmi_ack, mcu_irq_set;
`ifdef JTDD_COM_GUARD_EN
  logic [7:0]    viol_cnt;

  modport slave (
    input  cpu_cen, mcu_cen, com_cs, RnW, cpu_AB, cpu_dout, mcu_halt, mcu_nmi_set,
    input  mcu_A, mcu_cs, mcu_wr, mcu_dout, mcu_ba, mcu_nmi_ack, mcu_irq_set,
    output mcu_ram, mcu_ban, mcu_irqmain, mcu_din, mcu_haltn, mcu_nmin, viol_cnt
  );
  modport master (
    output cpu_cen, mcu_cen, com_cs, RnW, cpu_AB, cpu_dout, mcu_halt, mcu_nmi_set,
    output mcu_A, mcu_cs, mcu_wr, mcu_dout, mcu_ba, mcu_nmi_ack, mcu_irq_set,
    input  mcu_ram, mcu_ban, mcu_irqmain, mcu_din, mcu_haltn, mcu_nmin, viol_cnt
  );
`else
  modport slave (
    input  cpu_cen, mcu_cen, com_cs, RnW, cpu_AB, cpu_dout, mcu_halt, mcu_nmi_set,
    input  mcu_A, mcu_cs, mcu_wr, mcu_dout, mcu_ba, mcu_nmi_ack, mcu_irq_set,
    output mcu_ram, mcu_ban, mcu_irqmain, mcu_din, mcu_haltn, mcu_nmin
  );
  modport master (
    output cpu_cen, mcu_cen, com_cs, RnW, cpu_AB, cpu_dout, mcu_halt, mcu_nmi_set,
    output mcu_A, mcu_cs, mcu_wr, mcu_dout, mcu_ba, mcu_nmi_ack, mcu_irq_set,
    input  mcu_ram, mcu_ban, mcu_irqmain, mcu_din, mcu_haltn, mcu_nmin
  );
`endif
endinterface

// File: rtl/jtdd_com_dpram.sv
// True dual-port 2**AW x 8 RAM, 1-clk registered reads.
// Port A (main CPU) wins a same-address write collision; port B's write is dropped.
module jtdd_com_dpram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr_i,
  input  logic          a_we_i,
  input  logic [7:0]    a_din_i,
  output logic [7:0]    a_dout_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic          b_we_i,
  input  logic [7:0]    b_din_i,
  output logic [7:0]    b_dout_o
);
  logic [7:0] mem_q [2**AW];
  logic [7:0] a_dout_q, b_dout_q;
  logic       b_we_ok;

  assign b_we_ok = b_we_i & ~(a_we_i & (a_addr_i == b_addr_i));

  // Contents are never reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (a_we_i)  mem_q[a_addr_i] <= a_din_i;
    if (b_we_ok) mem_q[b_addr_i] <= b_din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dout_q <= 8'h00;
      b_dout_q <= 8'h00;
    end else begin
      a_dout_q <= mem_q[a_addr_i];
      b_dout_q <= mem_q[b_addr_i];
    end
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;
endmodule

// File: rtl/jtdd_mcu_com.sv
// Main CPU <-> MCU communication stage: halt/bus-available FSM, NMI latch, IRQ stretcher, shared RAM.
// Optional JTDD_COM_GUARD_EN: main access only while bus is granted, with a violation counter.
module jtdd_mcu_com
  import jtdd_com_pkg::*;
#(
  parameter int AW         = COM_AW,
  parameter int BA_TIMEOUT = COM_BA_TIMEOUT,
  parameter int IRQ_LEN    = COM_IRQ_LEN
) (
  input  logic           clk,
  input  logic           rst,
  jtdd_mcu_com_if.slave  bus
);
  localparam int CW = $clog2(BA_TIMEOUT + 1);
  localparam int IW = $clog2(IRQ_LEN + 1);

  com_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_clr, tmo;
  logic          ban_q, ban_d;
  logic          nmi_q;
  logic [IW-1:0] irq_q;
  logic          main_we, mcu_we;
  logic [7:0]    ram_rd;

  assign tmo = (cnt_q == CW'(BA_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ban_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ban_q   <= ban_d;
      if (cnt_clr)
        cnt_q <= '0;
      else if (bus.mcu_cen && (state_q == HALT_REQ || state_q == RELEASE) && !tmo)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      RUN: if (bus.mcu_halt) begin
        state_d = HALT_REQ;
        cnt_clr = 1'b1;
      end
      HALT_REQ:
        if (bus.mcu_ba || tmo) state_d = HALTED;
        else if (!bus.mcu_halt) begin
          state_d = RELEASE;
          cnt_clr = 1'b1;
        end
      HALTED: if (!bus.mcu_halt) begin
        state_d = RELEASE;
        cnt_clr = 1'b1;
      end
      RELEASE:
        if (!bus.mcu_ba || tmo) state_d = RUN;
        else if (bus.mcu_halt) begin
          state_d = HALT_REQ;
          cnt_clr = 1'b1;
        end
      default: state_d = RUN;
    endcase
    // Grant rises one clk after entering HALTED and drops on the exit edge itself.
    ban_d = (state_q == HALTED) && (state_d == HALTED);
  end

  assign bus.mcu_ban   = ban_q;
  assign bus.mcu_haltn = (state_q == RUN) || (state_q == RELEASE);

  // NMI latch: a set in the same clk as an ack wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                nmi_q <= 1'b0;
    else if (bus.mcu_nmi_set & bus.cpu_cen) nmi_q <= 1'b1;
    else if (bus.mcu_nmi_ack & bus.mcu_cen) nmi_q <= 1'b0;
  end
  assign bus.mcu_nmin = ~nmi_q;

  // Reloading while still high merges requests into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                irq_q <= '0;
    else if (bus.mcu_irq_set & bus.mcu_cen) irq_q <= IW'(IRQ_LEN);
    else if (irq_q != '0)                   irq_q <= irq_q - 1'b1;
  end
  assign bus.mcu_irqmain = (irq_q != '0);

  assign mcu_we = bus.mcu_cs & bus.mcu_wr & bus.mcu_cen;
`ifdef JTDD_COM_GUARD_EN
  logic [7:0] viol_q;
  assign main_we     = bus.com_cs & ~bus.RnW & bus.cpu_cen & ban_q;
  assign bus.mcu_ram = ban_q ? ram_rd : 8'hFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) viol_q <= 8'h00;
    else if (bus.com_cs && bus.cpu_cen && !ban_q && viol_q != 8'hFF)
      viol_q <= viol_q + 8'h01;
  end
  assign bus.viol_cnt = viol_q;
`else
  assign main_we     = bus.com_cs & ~bus.RnW & bus.cpu_cen;
  assign bus.mcu_ram = ram_rd;
`endif

  jtdd_com_dpram #(.AW(AW)) u_ram (
    .clk      (clk),
    .rst      (rst),
    .a_addr_i (bus.cpu_AB),
    .a_we_i   (main_we),
    .a_din_i  (bus.cpu_dout),
    .a_dout_o (ram_rd),
    .b_addr_i (bus.mcu_A),
    .b_we_i   (mcu_we),
    .b_din_i  (bus.mcu_dout),
    .b_dout_o (bus.mcu_din)
  );
endmodule

// File: tb/tb_jtdd_mcu_com.sv
// Self-checking bench for jtdd_mcu_com; RAM reads go through an expected-value queue.
module tb_jtdd_mcu_com;
`ifdef JTDD_COM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtdd_mcu_com_if #(.AW(9)) bus ();
  jtdd_mcu_com dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { string tag; bit port; logic [7:0] exp; } rd_t;
  rd_t        sb[$];
  logic [7:0] mem_m [512];
  bit         ban_m;
  int         errs = 0, chks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic main_wr(input logic [8:0] a, input logic [7:0] d);
    bus.com_cs = 1'b1; bus.RnW = 1'b0; bus.cpu_AB = a; bus.cpu_dout = d;
    tick();
    if (!GUARD || ban_m) mem_m[a] = d;
    bus.com_cs = 1'b0; bus.RnW = 1'b1;
  endtask

  task automatic mcu_wr(input logic [8:0] a, input logic [7:0] d);
    bus.mcu_cs = 1'b1; bus.mcu_wr = 1'b1; bus.mcu_A = a; bus.mcu_dout = d;
    tick();
    mem_m[a] = d;
    bus.mcu_cs = 1'b0; bus.mcu_wr = 1'b0;
  endtask

  // port 0 = main, 1 = MCU
  task automatic rd(input bit port, input logic [8:0] a, input string tag);
    rd_t e, got;
    e.tag = tag; e.port = port;
    e.exp = (port == 1'b0 && GUARD && !ban_m) ? 8'hFF : mem_m[a];
    if (port) begin bus.mcu_A = a; bus.mcu_cs = 1'b1; end
    else begin bus.cpu_AB = a; bus.com_cs = 1'b1; bus.RnW = 1'b1; end
    sb.push_back(e);
    tick();
    bus.mcu_cs = 1'b0; bus.com_cs = 1'b0;
    got = sb.pop_front();
    chk(got.tag, got.port ? bus.mcu_din : bus.mcu_ram, got.exp);
  endtask

  task automatic wait_ban(input logic v, input int budget, input string tag);
    int n = 0;
    while (bus.mcu_ban !== v && n < budget) begin tick(); n++; end
    chk(tag, bus.mcu_ban, v);
  endtask

  initial begin
    int hi, rises;
    logic prev;
    bus.cpu_cen = 1'b1; bus.mcu_cen = 1'b1;
    bus.com_cs = 1'b0; bus.RnW = 1'b1; bus.cpu_AB = '0; bus.cpu_dout = '0;
    bus.mcu_halt = 1'b0; bus.mcu_nmi_set = 1'b0;
    bus.mcu_A = '0; bus.mcu_cs = 1'b0; bus.mcu_wr = 1'b0; bus.mcu_dout = '0;
    bus.mcu_ba = 1'b0; bus.mcu_nmi_ack = 1'b0; bus.mcu_irq_set = 1'b0;
    ban_m = 1'b0;
    #2;
    chk("rst_ban", bus.mcu_ban, 1'b0);
    chk("rst_haltn", bus.mcu_haltn, 1'b1);
    chk("rst_ram", bus.mcu_ram, GUARD ? 8'hFF : 8'h00);
    chk("rst_din", bus.mcu_din, 8'h00);
    tick(); tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("idle_ban", bus.mcu_ban, 1'b0);
    chk("idle_haltn", bus.mcu_haltn, 1'b1);
    chk("idle_nmin", bus.mcu_nmin, 1'b1);
    chk("idle_irq", bus.mcu_irqmain, 1'b0);

    // handshake with mcu_ba answering after 5 mcu_cen
    bus.mcu_halt = 1'b1;
    tick();
    chk("hs_haltn0", bus.mcu_haltn, 1'b0);
    repeat (5) tick();
    chk("hs_ban_wait", bus.mcu_ban, 1'b0);
    bus.mcu_ba = 1'b1;
    tick();
    wait_ban(1'b1, 3, "hs_ban1");
    bus.mcu_halt = 1'b0;
    tick();
    chk("hs_rel_ban", bus.mcu_ban, 1'b0);
    chk("hs_rel_haltn", bus.mcu_haltn, 1'b1);
    bus.mcu_ba = 1'b0;
    tick();
    chk("hs_run_haltn", bus.mcu_haltn, 1'b1);

    // timeout: mcu_ba never answers, mcu_cen every other clk
    bus.mcu_halt = 1'b1;
    bus.mcu_cen = 1'b0;
    tick();
    repeat (250) begin bus.mcu_cen = 1'b1; tick(); bus.mcu_cen = 1'b0; tick(); end
    chk("tmo_early", bus.mcu_ban, 1'b0);
    repeat (10) begin bus.mcu_cen = 1'b1; tick(); bus.mcu_cen = 1'b0; tick(); end
    chk("tmo_ban", bus.mcu_ban, 1'b1);
    bus.mcu_cen = 1'b1;
    bus.mcu_halt = 1'b0;
    tick(); tick();
    chk("tmo_rel_haltn", bus.mcu_haltn, 1'b1);
    chk("tmo_rel_ban", bus.mcu_ban, 1'b0);

    // grant the bus for RAM traffic
    bus.mcu_halt = 1'b1; bus.mcu_ba = 1'b1;
    tick();
    wait_ban(1'b1, 4, "ram_grant");
    ban_m = 1'b1;
    main_wr(9'h1FF, 8'h5A);
    rd(1'b1, 9'h1FF, "rd_mcu_1ff");
    rd(1'b0, 9'h1FF, "rd_main_1ff");
    // same-address collision: main wins
    bus.com_cs = 1'b1; bus.RnW = 1'b0; bus.cpu_AB = 9'h010; bus.cpu_dout = 8'h11;
    bus.mcu_cs = 1'b1; bus.mcu_wr = 1'b1; bus.mcu_A = 9'h010; bus.mcu_dout = 8'h22;
    tick();
    mem_m[9'h010] = 8'h11;
    bus.com_cs = 1'b0; bus.RnW = 1'b1; bus.mcu_cs = 1'b0; bus.mcu_wr = 1'b0;
    rd(1'b1, 9'h010, "coll_mcu");
    rd(1'b0, 9'h010, "coll_main");
    // different addresses in one clk both land
    bus.com_cs = 1'b1; bus.RnW = 1'b0; bus.cpu_AB = 9'h021; bus.cpu_dout = 8'hA1;
    bus.mcu_cs = 1'b1; bus.mcu_wr = 1'b1; bus.mcu_A = 9'h022; bus.mcu_dout = 8'hB2;
    tick();
    mem_m[9'h021] = 8'hA1; mem_m[9'h022] = 8'hB2;
    bus.com_cs = 1'b0; bus.RnW = 1'b1; bus.mcu_cs = 1'b0; bus.mcu_wr = 1'b0;
    rd(1'b0, 9'h022, "dual_main");
    rd(1'b1, 9'h021, "dual_mcu");
    mcu_wr(9'h000, 8'h3C);
    main_wr(9'h030, 8'h44);
    rd(1'b0, 9'h000, "rd_main_000");

    // release, then main traffic with the bus not granted
    bus.mcu_halt = 1'b0; bus.mcu_ba = 1'b0;
    tick();
    ban_m = 1'b0;
    chk("rel_ban", bus.mcu_ban, 1'b0);
    tick();
    main_wr(9'h030, 8'h77);
    rd(1'b1, 9'h030, "nogrant_wr");
    rd(1'b0, 9'h1FF, "nogrant_rd");

    // NMI latch
    bus.mcu_nmi_set = 1'b1; tick(); bus.mcu_nmi_set = 1'b0;
    chk("nmi_set", bus.mcu_nmin, 1'b0);
    bus.mcu_nmi_set = 1'b1; bus.mcu_nmi_ack = 1'b1; tick();
    bus.mcu_nmi_set = 1'b0; bus.mcu_nmi_ack = 1'b0;
    chk("nmi_set_wins", bus.mcu_nmin, 1'b0);
    tick();
    bus.mcu_nmi_ack = 1'b1; tick(); bus.mcu_nmi_ack = 1'b0;
    chk("nmi_ack", bus.mcu_nmin, 1'b1);

    // IRQ: two requests 2 clk apart merge into one 6-clk pulse
    chk("irq_idle", bus.mcu_irqmain, 1'b0);
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.mcu_irq_set = (i == 0 || i == 2);
      tick();
      if (bus.mcu_irqmain && !prev) rises++;
      if (bus.mcu_irqmain) hi++;
      prev = bus.mcu_irqmain;
    end
    bus.mcu_irq_set = 1'b0;
    chk("irq_len", hi, 6);
    chk("irq_rises", rises, 1);

    // reset in the middle of a granted handshake keeps RAM
    bus.mcu_halt = 1'b1; bus.mcu_ba = 1'b1;
    tick();
    wait_ban(1'b1, 4, "mid_grant");
    bus.mcu_nmi_set = 1'b1; tick(); bus.mcu_nmi_set = 1'b0;
    rst = 1'b1; bus.mcu_halt = 1'b0; bus.mcu_ba = 1'b0;
    #1;
    chk("mid_rst_ban", bus.mcu_ban, 1'b0);
    chk("mid_rst_haltn", bus.mcu_haltn, 1'b1);
    chk("mid_rst_nmin", bus.mcu_nmin, 1'b1);
    tick();
    rst = 1'b0;
    ban_m = 1'b0;
    rd(1'b1, 9'h1FF, "ram_kept");

`ifdef JTDD_COM_GUARD_EN
    $display("guard violations seen: %0d", bus.viol_cnt);
`endif
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
